// File: rtl/alu_result_buffer.sv
// First-word-fall-through buffer for ALU results and flags, with saturating
// error/drop statistics and a sticky overflow bit.
module alu_result_buffer #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_valid,
   input  logic [DATA_WIDTH-1:0]      i_result,
   input  logic [3:0]                 i_flag,
   output logic                       o_ready,
   input  logic                       i_pop,
   output logic                       o_valid,
   output logic [DATA_WIDTH-1:0]      o_result,
   output logic [3:0]                 o_flag,
   output logic [$clog2(DEPTH):0]     o_count,
   input  logic                       i_clr_stats,
   output logic [CNT_WIDTH-1:0]       o_err_cnt,
   output logic [CNT_WIDTH-1:0]       o_drop_cnt,
   output logic                       o_sticky_ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = DATA_WIDTH + 4;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [EW-1:0]        r_mem [DEPTH];
   logic [AW-1:0]        r_wptr;
   logic [AW-1:0]        r_rptr;
   logic [AW:0]          r_count;
   logic [CNT_WIDTH-1:0] r_err_cnt;
   logic [CNT_WIDTH-1:0] r_drop_cnt;
   logic                 r_sticky_ovf;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic          w_err;
   logic [EW-1:0] w_head;

   always_comb begin
      w_full  = (r_count == FULL_CNT);
      w_empty = (r_count == '0);
      w_push  = i_valid && !w_full;
      w_drop  = i_valid && w_full;
      w_pop   = i_pop && !w_empty;
      w_err   = i_flag[0] || i_flag[3];
      w_head  = r_mem[r_rptr];
   end

   // Storage is not reset; the head outputs are gated by occupancy instead.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {i_flag, i_result};
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Clear wins over any increment in the same cycle.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_err_cnt    <= '0;
         r_drop_cnt   <= '0;
         r_sticky_ovf <= 1'b0;
      end else if (i_clr_stats) begin
         r_err_cnt    <= '0;
         r_drop_cnt   <= '0;
         r_sticky_ovf <= 1'b0;
      end else begin
         if (w_push && w_err && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
         if (w_drop && (r_drop_cnt != CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
         if (w_push && i_flag[3]) begin
            r_sticky_ovf <= 1'b1;
         end
      end
   end

   always_comb begin
      o_ready      = !w_full;
      o_valid      = !w_empty;
      o_count      = r_count;
      o_result     = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
      o_flag       = w_empty ? '0 : w_head[EW-1:DATA_WIDTH];
      o_err_cnt    = r_err_cnt;
      o_drop_cnt   = r_drop_cnt;
      o_sticky_ovf = r_sticky_ovf;
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: a default instance plus a CNT_WIDTH=2
// instance on the same stimulus for counter saturation.
module tb_alu_result_buffer;

   logic       i_clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic       i_valid = 1'b0;
   logic [3:0] i_result = '0;
   logic [3:0] i_flag = '0;
   logic       i_pop = 1'b0;
   logic       i_clr_stats = 1'b0;

   logic       o_ready, o_valid, o_sticky_ovf;
   logic [3:0] o_result, o_flag, o_count;
   logic [7:0] o_err_cnt, o_drop_cnt;

   logic       s_ready, s_valid, s_sticky_ovf;
   logic [3:0] s_result, s_flag, s_count;
   logic [1:0] s_err_cnt, s_drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   alu_result_buffer #(.DATA_WIDTH(4), .DEPTH(8), .CNT_WIDTH(8)) u_dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_result(i_result),
      .i_flag(i_flag), .o_ready(o_ready), .i_pop(i_pop), .o_valid(o_valid),
      .o_result(o_result), .o_flag(o_flag), .o_count(o_count),
      .i_clr_stats(i_clr_stats), .o_err_cnt(o_err_cnt), .o_drop_cnt(o_drop_cnt),
      .o_sticky_ovf(o_sticky_ovf)
   );

   alu_result_buffer #(.DATA_WIDTH(4), .DEPTH(8), .CNT_WIDTH(2)) u_dut_sat (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_result(i_result),
      .i_flag(i_flag), .o_ready(s_ready), .i_pop(i_pop), .o_valid(s_valid),
      .o_result(s_result), .o_flag(s_flag), .o_count(s_count),
      .i_clr_stats(i_clr_stats), .o_err_cnt(s_err_cnt), .o_drop_cnt(s_drop_cnt),
      .o_sticky_ovf(s_sticky_ovf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, sample 1 ns after the edge, then idle inputs.
   task automatic drive(input logic v, input logic [3:0] res, input logic [3:0] flg,
                        input logic pop, input logic clr);
      i_valid     = v;
      i_result    = res;
      i_flag      = flg;
      i_pop       = pop;
      i_clr_stats = clr;
      @(posedge i_clk);
      #1;
      i_valid     = 1'b0;
      i_result    = '0;
      i_flag      = '0;
      i_pop       = 1'b0;
      i_clr_stats = 1'b0;
   endtask

   task automatic push(input logic [3:0] res, input logic [3:0] flg);
      drive(1'b1, res, flg, 1'b0, 1'b0);
   endtask

   task automatic pop_expect(input string tag, input logic [3:0] exp);
      check_eq(tag, {31'd0, o_valid}, 32'd1);
      check_eq(tag, {28'd0, o_result}, {28'd0, exp});
      drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
   endtask

   initial begin
      // Reset state
      #12;
      check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
      check_eq("rst_ready", {31'd0, o_ready}, 32'd1);
      check_eq("rst_count", {28'd0, o_count}, 32'd0);
      check_eq("rst_result", {28'd0, o_result}, 32'd0);
      check_eq("rst_flag", {28'd0, o_flag}, 32'd0);
      check_eq("rst_err", {24'd0, o_err_cnt}, 32'd0);
      check_eq("rst_drop", {24'd0, o_drop_cnt}, 32'd0);
      check_eq("rst_sticky", {31'd0, o_sticky_ovf}, 32'd0);
      #5 i_rstn = 1'b1;
      @(negedge i_clk);

      // Single entry and fall-through latency
      push(4'b1000, 4'b0010);
      check_eq("single_valid", {31'd0, o_valid}, 32'd1);
      check_eq("single_result", {28'd0, o_result}, 32'h8);
      check_eq("single_flag", {28'd0, o_flag}, 32'h2);
      check_eq("single_count", {28'd0, o_count}, 32'd1);
      drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      check_eq("single_empty_valid", {31'd0, o_valid}, 32'd0);
      check_eq("single_empty_result", {28'd0, o_result}, 32'd0);
      check_eq("single_empty_flag", {28'd0, o_flag}, 32'd0);

      // Fill past capacity
      for (int i = 0; i < 10; i++) begin
         push(4'(i), 4'b0000);
         if (i == 7) check_eq("fill_ready", {31'd0, o_ready}, 32'd0);
      end
      check_eq("fill_drop", {24'd0, o_drop_cnt}, 32'd2);
      check_eq("fill_count", {28'd0, o_count}, 32'd8);
      for (int i = 0; i < 8; i++) pop_expect("fill_order", 4'(i));
      check_eq("fill_drained", {28'd0, o_count}, 32'd0);

      // Pointers start at 1 here, so 8 pushes wrap around the array
      for (int i = 0; i < 8; i++) push(4'(i + 10), 4'b0000);
      check_eq("wrap_count", {28'd0, o_count}, 32'd8);
      for (int i = 0; i < 8; i++) pop_expect("wrap_order", 4'(i + 10));

      // Simultaneous push/pop while partial
      push(4'd3, 4'b0000);
      push(4'd5, 4'b0000);
      push(4'd7, 4'b0000);
      drive(1'b1, 4'd9, 4'b0000, 1'b1, 1'b0);
      check_eq("partial_count", {28'd0, o_count}, 32'd3);
      pop_expect("partial_order", 4'd5);
      pop_expect("partial_order", 4'd7);
      pop_expect("partial_order", 4'd9);

      // Simultaneous push/pop while full: push is dropped
      for (int i = 0; i < 8; i++) push(4'(i), 4'b0000);
      drive(1'b1, 4'd15, 4'b0000, 1'b1, 1'b0);
      check_eq("full_drop", {24'd0, o_drop_cnt}, 32'd3);
      check_eq("full_count", {28'd0, o_count}, 32'd7);
      for (int i = 1; i < 8; i++) pop_expect("full_order", 4'(i));
      check_eq("full_drained", {31'd0, o_valid}, 32'd0);

      // Simultaneous push/pop while empty: push accepted
      drive(1'b1, 4'd6, 4'b0000, 1'b1, 1'b0);
      check_eq("empty_pp_count", {28'd0, o_count}, 32'd1);
      pop_expect("empty_pp_head", 4'd6);

      // Statistics
      push(4'd1, 4'b0001);
      push(4'd2, 4'b1000);
      push(4'd3, 4'b1001);
      push(4'd4, 4'b0100);
      check_eq("stat_err", {24'd0, o_err_cnt}, 32'd3);
      check_eq("stat_sticky", {31'd0, o_sticky_ovf}, 32'd1);
      check_eq("stat_drop", {24'd0, o_drop_cnt}, 32'd3);
      push(4'd5, 4'b0001);
      check_eq("stat_err5", {24'd0, o_err_cnt}, 32'd4);
      check_eq("stat_count5", {28'd0, o_count}, 32'd5);

      // Asynchronous reset between edges
      #3 i_rstn = 1'b0;
      #1;
      check_eq("arst_valid", {31'd0, o_valid}, 32'd0);
      check_eq("arst_count", {28'd0, o_count}, 32'd0);
      check_eq("arst_ready", {31'd0, o_ready}, 32'd1);
      check_eq("arst_err", {24'd0, o_err_cnt}, 32'd0);
      check_eq("arst_drop", {24'd0, o_drop_cnt}, 32'd0);
      check_eq("arst_sticky", {31'd0, o_sticky_ovf}, 32'd0);
      #1 i_rstn = 1'b1;
      push(4'hC, 4'b1001);
      check_eq("post_rst_result", {28'd0, o_result}, 32'hC);
      check_eq("post_rst_flag", {28'd0, o_flag}, 32'h9);
      check_eq("post_rst_count", {28'd0, o_count}, 32'd1);
      check_eq("post_rst_err", {24'd0, o_err_cnt}, 32'd1);

      // Clear has priority over a same-cycle ERR push; the entry is still stored
      push(4'hD, 4'b0001);
      check_eq("pre_clr_err", {24'd0, o_err_cnt}, 32'd2);
      drive(1'b1, 4'hE, 4'b0001, 1'b0, 1'b1);
      check_eq("clr_err", {24'd0, o_err_cnt}, 32'd0);
      check_eq("clr_drop", {24'd0, o_drop_cnt}, 32'd0);
      check_eq("clr_sticky", {31'd0, o_sticky_ovf}, 32'd0);
      check_eq("clr_count", {28'd0, o_count}, 32'd3);
      pop_expect("clr_order", 4'hC);
      pop_expect("clr_order", 4'hD);
      check_eq("clr_flag_kept", {28'd0, o_flag}, 32'h1);
      pop_expect("clr_order", 4'hE);

      // Saturation on the 2-bit counter instance
      for (int k = 1; k <= 6; k++) begin
         drive(1'b1, 4'(k), 4'b0001, 1'b1, 1'b0);
         check_eq("sat_err2", {30'd0, s_err_cnt}, (k > 3) ? 32'd3 : 32'(k));
         check_eq("sat_err8", {24'd0, o_err_cnt}, 32'(k));
      end
      check_eq("sat_count", {28'd0, o_count}, 32'd1);
      pop_expect("sat_last", 4'd6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the `TOP` ALU that captures each registered ALU result together with its 4-bit flag vector into a first-word-fall-through FIFO. It lets a slower consumer drain results at its own rate and keeps running statistics: error/overflow event count, dropped-result count, and sticky overflow. The ALU has no backpressure, so results offered while the buffer is full are dropped and counted.

## Interface
Parameters:
- DATA_WIDTH, 4, width of ALU result; matches ALU `o_result`
- DEPTH, 8, FIFO entries; power of two, at least 2
- CNT_WIDTH, 8, width of each saturating statistics counter

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_valid  in  1  ALU result present this cycle
- i_result  in  DATA_WIDTH  ALU `o_result`
- i_flag  in  4  ALU `o_flag`: bit0 ERR, bit1 NEG, bit2 POS, bit3 OVERFLOW
- o_ready  out  1  high when count < DEPTH; informational only, the ALU ignores it
- i_pop  in  1  consumer takes the head entry
- o_valid  out  1  head entry valid (count > 0)
- o_result  out  DATA_WIDTH  head result
- o_flag  out  4  head flags
- o_count  out  $clog2(DEPTH)+1  current occupancy
- i_clr_stats  in  1  synchronous clear of statistics
- o_err_cnt  out  CNT_WIDTH  accepted entries with ERR or OVERFLOW set; saturates
- o_drop_cnt  out  CNT_WIDTH  offers dropped because the FIFO was full; saturates
- o_sticky_ovf  out  1  set by any accepted entry with OVERFLOW; cleared by i_clr_stats

## Operation
- Storage: DEPTH x (DATA_WIDTH+4) register array. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- Push: a push occurs when i_valid=1 and count<DEPTH. The entry {i_flag, i_result} is written at wptr and wptr increments.
- Drop: i_valid=1 with count==DEPTH. Nothing is written. o_drop_cnt increments unless it is at its maximum value (2^CNT_WIDTH-1).
- Pop: a pop occurs when i_pop=1 and count>0. rptr increments. i_pop while empty is ignored with no side effects.
- Count update:
  - push only: count+1
  - pop only: count-1
  - both, or neither: unchanged
- Full and simultaneous pop: o_ready is evaluated on the pre-edge count, so a push offered while full is dropped even if a pop occurs in the same cycle.
- Empty and simultaneous push+pop: the pop is ignored and the push is accepted.
- Outputs are fall-through. o_result and o_flag show mem[rptr] whenever o_valid=1 and are 0 when empty.
- Statistics are updated on accepted pushes only:
  - o_err_cnt increments (saturating) if i_flag[0] or i_flag[3] is set.
  - o_sticky_ovf is set if i_flag[3] is set.
- i_clr_stats:
  - Zeroes o_err_cnt, o_drop_cnt and o_sticky_ovf. It has priority over any increment in the same cycle.
  - Does not affect FIFO contents.
- There is no explicit FSM. Occupancy states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), all derived from the count register.

## Timing
- Reset (i_rstn low, asynchronous):
  - Pointers, count, o_err_cnt, o_drop_cnt and o_sticky_ovf go to 0.
  - o_valid=0, o_ready=1, o_result=0, o_flag=0.
  - Stored entries are discarded.
- Reset asserted mid-operation clears all state immediately, regardless of the clock. The first push is accepted on the first rising edge with i_rstn high.
- Latency: an entry pushed at edge N is visible on o_result/o_flag with o_valid=1 after edge N when the FIFO was empty. There are no extra pipeline stages.
- o_valid, o_ready and o_count change only after a rising edge or on reset. They are never combinational from i_valid or i_pop.
- Sustained throughput is one push and one pop per cycle.
- Counters are updated at the same edge as the accepted push or drop.

## Test plan
- Reset and single entry:
  - Stimulus: reset; push result=4'b1000 with flag=4'b0010 (NEG).
  - Required: after the edge, o_valid=1, o_result=1000, o_flag=0010, o_count=1. Pop, and o_valid returns to 0 with outputs at 0.
- Fill, overflow and wrap:
  - Stimulus: push 10 entries (values 0..9) with no pops; then pop all.
  - Required: o_ready=0 after the 8th push, o_drop_cnt=2, o_count=8. Pops return 0..7 in order.
  - Stimulus: push 8 more entries.
  - Required: pointers wrap and pops read back in correct order.
- Simultaneous push/pop:
  - Partial at count=3: count stays 3 and order is preserved.
  - Full: the push is dropped, o_drop_cnt increments, and count goes to 7.
  - Empty: the push is accepted and count goes to 1.
- Statistics:
  - Stimulus: push flags 0001 (ERR), 1000 (OVF), 1001 (ERR and OVF), then 0100 (POS).
  - Required: o_err_cnt=3 and o_sticky_ovf=1.
  - Stimulus: assert i_clr_stats together with an ERR push.
  - Required: all three statistics read 0 afterwards and the entry is still stored.
- Saturation: with CNT_WIDTH=2, drive 6 ERR pushes with pops. o_err_cnt must hold at 3.
- Reset mid-stream:
  - Stimulus: with count=5, pulse i_rstn low between clock edges.
  - Required: o_valid=0, o_count=0 and counters 0 immediately, without waiting for a clock edge. The next push after reset is read back correctly.
